// File: rtl/ac97_pkg.sv
// Shared types, register indices, init ROM contents and slot packing helpers
// for the AC97 control-slot command scheduler.
package ac97_pkg;

  typedef enum logic [1:0] {
    WAIT_READY,
    INIT,
    IDLE,
    READ_WAIT
  } state_t;

  localparam logic [6:0] REG_RESET       = 7'h00;
  localparam logic [6:0] REG_MASTER_VOL  = 7'h02;
  localparam logic [6:0] REG_HP_VOL      = 7'h04;
  localparam logic [6:0] REG_PCM_OUT_VOL = 7'h18;
  localparam logic [6:0] REG_POWERDOWN   = 7'h26;

  localparam int unsigned SLOT_W     = 20;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned INIT_LEN   = 4;
  localparam int unsigned INIT_IDX_W = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } init_entry_t;

  // Entry 0 sits in the low slice, so index order matches issue order.
  localparam init_entry_t [INIT_LEN-1:0] INIT_ROM = {
    init_entry_t'{addr: REG_HP_VOL,      data: 16'h0000},
    init_entry_t'{addr: REG_PCM_OUT_VOL, data: 16'h0808},
    init_entry_t'{addr: REG_MASTER_VOL,  data: 16'h0000},
    init_entry_t'{addr: REG_RESET,       data: 16'h0000}
  };

  function automatic logic [SLOT_W-1:0] pack_slot1(input logic rnw,
                                                   input logic [ADDR_W-1:0] addr);
    return {rnw, addr, 12'h000};
  endfunction

  function automatic logic [SLOT_W-1:0] pack_slot2(input logic [DATA_W-1:0] data);
    return {data, 4'h0};
  endfunction

endpackage

// File: rtl/ac97_init_rom.sv
// Combinational init-sequence lookup: index -> {register, value} plus last-entry flag.
module ac97_init_rom
  import ac97_pkg::*;
(
  input  logic [INIT_IDX_W-1:0] idx,
  output logic [ADDR_W-1:0]     addr_c,
  output logic [DATA_W-1:0]     data_c,
  output logic                  last_c
);

  init_entry_t entry;

  assign entry  = INIT_ROM[idx];
  assign addr_c = entry.addr;
  assign data_c = entry.data;
  assign last_c = (idx == INIT_IDX_W'(INIT_LEN - 1));

endmodule

// File: rtl/ac97_cmd_sched.sv
// AC97 slot-1/2 command scheduler: codec init, host register access and
// optional 0x26 status polling (enabled by defining AC97_STATUS_POLL_EN).
module ac97_cmd_sched
  import ac97_pkg::*;
#(
  parameter int unsigned TIMEOUT_FRAMES = 4,
  parameter int unsigned POLL_FRAMES    = 48
) (
  input  logic        ac97_bitclk,
  input  logic        ac97_rst_b,
  input  logic        ac97_strobe,
  input  logic        in_codec_ready,
  input  logic        in_slot1_valid,
  input  logic        in_slot2_valid,
  input  logic [19:0] in_slot1,
  input  logic [19:0] in_slot2,
  output logic [19:0] ac97_out_slot1,
  output logic        ac97_out_slot1_valid,
  output logic [19:0] ac97_out_slot2,
  output logic        ac97_out_slot2_valid,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rnw,
  input  logic [6:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic        init_done,
  output logic [15:0] pwr_status
);

  localparam int unsigned TO_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;

  state_t                  state;
  logic [INIT_IDX_W-1:0]   init_idx;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_data;
  logic                    rom_last;
  logic                    buf_valid;
  logic                    buf_rnw;
  logic [ADDR_W-1:0]       buf_addr;
  logic [DATA_W-1:0]       buf_wdata;
  logic                    host_busy;
  logic [ADDR_W-1:0]       pend_addr;
  logic [TO_W-1:0]         wait_cnt;
  logic                    accept;
  logic                    slot_match;
  logic                    wait_expired;
  logic                    unused_bits;

  ac97_init_rom u_init_rom (
    .idx    (init_idx),
    .addr_c (rom_addr),
    .data_c (rom_data),
    .last_c (rom_last)
  );

  assign accept       = req_valid & req_ready;
  assign slot_match   = in_slot1_valid & in_slot2_valid & (in_slot1[18:12] == pend_addr);
  assign wait_expired = (wait_cnt == TO_W'(TIMEOUT_FRAMES - 1));
  assign unused_bits  = ^{in_slot1[19], in_slot1[11:0], in_slot2[3:0]};

`ifdef AC97_STATUS_POLL_EN
  localparam int unsigned POLL_W = (POLL_FRAMES > 1) ? $clog2(POLL_FRAMES) : 1;

  logic [POLL_W-1:0] poll_cnt;
  logic              poll_pend;
  logic              pend_poll;
  logic [15:0]       pwr_q;

  // Frame counter that raises a single pending poll per wrap.
  always_ff @(posedge ac97_bitclk or negedge ac97_rst_b) begin
    if (!ac97_rst_b) begin
      poll_cnt  <= '0;
      poll_pend <= 1'b0;
    end else if (ac97_strobe) begin
      if (state == IDLE && in_codec_ready && !buf_valid && poll_pend) begin
        poll_pend <= 1'b0;
      end else if (init_done && poll_cnt == POLL_W'(POLL_FRAMES - 1)) begin
        poll_pend <= 1'b1;
      end
      if (init_done) begin
        poll_cnt <= (poll_cnt == POLL_W'(POLL_FRAMES - 1)) ? '0 : poll_cnt + POLL_W'(1);
      end
    end
  end

  assign pwr_status = pwr_q;
`else
  localparam int unsigned unused_poll_frames = POLL_FRAMES;

  logic pend_poll;

  assign pend_poll  = 1'b0;
  assign pwr_status = 16'h0000;
`endif

  // Scheduler FSM, host buffer and all registered outputs.
  always_ff @(posedge ac97_bitclk or negedge ac97_rst_b) begin
    if (!ac97_rst_b) begin
      state                <= WAIT_READY;
      init_idx             <= '0;
      buf_valid            <= 1'b0;
      buf_rnw              <= 1'b0;
      buf_addr             <= '0;
      buf_wdata            <= '0;
      host_busy            <= 1'b0;
      pend_addr            <= '0;
      wait_cnt             <= '0;
      ac97_out_slot1       <= '0;
      ac97_out_slot1_valid <= 1'b0;
      ac97_out_slot2       <= '0;
      ac97_out_slot2_valid <= 1'b0;
      req_ready            <= 1'b0;
      resp_valid           <= 1'b0;
      resp_data            <= 16'h0000;
      resp_err             <= 1'b0;
      init_done            <= 1'b0;
`ifdef AC97_STATUS_POLL_EN
      pend_poll            <= 1'b0;
      pwr_q                <= 16'h0000;
`endif
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        buf_valid <= 1'b1;
        buf_rnw   <= req_rnw;
        buf_addr  <= req_addr;
        buf_wdata <= req_wdata;
        host_busy <= 1'b1;
      end else if (resp_valid) begin
        host_busy <= 1'b0;
      end
      // Ready reopens only after the previous response pulse has been seen.
      req_ready <= init_done & ~accept & ~(host_busy & ~resp_valid);

      if (ac97_strobe) begin
        ac97_out_slot1       <= '0;
        ac97_out_slot1_valid <= 1'b0;
        ac97_out_slot2       <= '0;
        ac97_out_slot2_valid <= 1'b0;
        case (state)
          WAIT_READY: begin
            if (in_codec_ready) state <= INIT;
          end
          INIT: begin
            ac97_out_slot1       <= pack_slot1(1'b0, rom_addr);
            ac97_out_slot1_valid <= 1'b1;
            ac97_out_slot2       <= pack_slot2(rom_data);
            ac97_out_slot2_valid <= 1'b1;
            if (rom_last) begin
              init_done <= 1'b1;
              init_idx  <= '0;
              state     <= IDLE;
            end else begin
              init_idx <= init_idx + INIT_IDX_W'(1);
            end
          end
          IDLE: begin
            if (!in_codec_ready) begin
              init_done <= 1'b0;
              init_idx  <= '0;
              state     <= WAIT_READY;
            end else if (buf_valid) begin
              buf_valid            <= 1'b0;
              ac97_out_slot1       <= pack_slot1(buf_rnw, buf_addr);
              ac97_out_slot1_valid <= 1'b1;
              if (buf_rnw) begin
                pend_addr <= buf_addr;
                wait_cnt  <= '0;
`ifdef AC97_STATUS_POLL_EN
                pend_poll <= 1'b0;
`endif
                state     <= READ_WAIT;
              end else begin
                ac97_out_slot2       <= pack_slot2(buf_wdata);
                ac97_out_slot2_valid <= 1'b1;
                resp_valid           <= 1'b1;
                resp_err             <= 1'b0;
              end
            end
`ifdef AC97_STATUS_POLL_EN
            else if (poll_pend) begin
              ac97_out_slot1       <= pack_slot1(1'b1, REG_POWERDOWN);
              ac97_out_slot1_valid <= 1'b1;
              pend_addr            <= REG_POWERDOWN;
              wait_cnt             <= '0;
              pend_poll            <= 1'b1;
              state                <= READ_WAIT;
            end
`endif
          end
          READ_WAIT: begin
            if (!in_codec_ready) begin
              if (!pend_poll) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
                resp_data  <= 16'hFFFF;
              end
              init_done <= 1'b0;
              init_idx  <= '0;
              state     <= WAIT_READY;
            end else if (slot_match) begin
              if (!pend_poll) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b0;
                resp_data  <= in_slot2[19:4];
              end
`ifdef AC97_STATUS_POLL_EN
              else begin
                pwr_q <= in_slot2[19:4];
              end
`endif
              state <= IDLE;
            end else if (wait_expired) begin
              if (!pend_poll) begin
                resp_valid <= 1'b1;
                resp_err   <= 1'b1;
                resp_data  <= 16'hFFFF;
              end
              state <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + TO_W'(1);
            end
          end
          default: state <= WAIT_READY;
        endcase
      end
    end
  end

endmodule

// File: doc/ac97_cmd_sched.md
Name: ac97_cmd_sched

Overview:
- Frame-level command scheduler for the AC97 control slots (out slot 1 = command address, out slot 2 = command data).
- After codec-ready, it runs a fixed init sequence. It then shares the slot-1/2 command channel between a host register-access port and an optional periodic status poll.
- It captures codec read responses from input slots 1/2.
- Sits between the register/IO side and the AC-link serializer. Uses the link's per-frame strobe as its only timing reference.

Parameters:
- TIMEOUT_FRAMES, 4: frames to wait for a matching read response before declaring an error.
- POLL_FRAMES, 48: frames between status polls (1 ms at 48 kHz).

Ports:
- ac97_bitclk  in  1  AC-link bit clock; sole clock.
- ac97_rst_b  in  1  asynchronous, active-low reset.
- ac97_strobe  in  1  one-cycle pulse per 256-bit frame.
- in_codec_ready  in  1  input TAG bit 15 of the last completed frame.
- in_slot1_valid  in  1  input TAG bit 14.
- in_slot2_valid  in  1  input TAG bit 13.
- in_slot1  in  20  status address; [18:12] = register index.
- in_slot2  in  20  status data; [19:4] = register value.
- ac97_out_slot1  out  20  {rnw, addr[6:0], 12'b0}.
- ac97_out_slot1_valid  out  1  slot-1 tag bit.
- ac97_out_slot2  out  20  {wdata[15:0], 4'b0}.
- ac97_out_slot2_valid  out  1  slot-2 tag bit.
- req_valid  in  1  host command present.
- req_ready  out  1  host command accepted this cycle when req_valid is also high.
- req_rnw  in  1  1 = read, 0 = write.
- req_addr  in  7  codec register index.
- req_wdata  in  16  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  16  read data; 0xFFFF on error.
- resp_err  out  1  read timed out.
- init_done  out  1  init sequence complete.
- pwr_status  out  16  cached value of register 0x26.

Behaviour:
- Reset (async, ac97_rst_b = 0):
  - Enter WAIT_READY; init index = 0; poll counter = 0; poll-pending flag = 0.
  - All outputs 0, except resp_data = 0x0000 and pwr_status = 0x0000.
- Slot outputs:
  - Registered; update only on the ac97_bitclk edge where ac97_strobe = 1, then hold for the whole frame.
  - In frames with no command, slot1/slot2 valid = 0 and data = 0.
- States (all transitions occur only on strobe edges, except host-accept):
  - WAIT_READY: no commands. Go to INIT when in_codec_ready = 1.
  - INIT: issue one ROM write per frame with both valids = 1. ROM, in order:
    - 0x00 <- 0x0000
    - 0x02 <- 0x0000
    - 0x18 <- 0x0808
    - 0x04 <- 0x0000

    After the last entry, set init_done = 1 and go to IDLE.
  - IDLE:
    - If in_codec_ready = 0: go to WAIT_READY, clear init_done, restart init from index 0. A buffered host command stays buffered.
    - Else if a host command is buffered: issue it (host has priority).
      - Write: slot1 rnw = 0, both valids = 1. Pulse resp_valid (err = 0, data unchanged) on the same edge. Stay in IDLE.
      - Read: slot1 rnw = 1, slot1 valid = 1, slot2 valid = 0, slot2 data = 0. Go to READ_WAIT.
    - Else if poll is pending: issue a read of 0x26 and go to READ_WAIT (poll).
  - READ_WAIT: no commands issued. On each strobe edge:
    - Match (in_slot1_valid & in_slot2_valid & in_slot1[18:12] == pending addr): capture in_slot2[19:4] and return to IDLE.
      - Host read: resp_valid = 1, resp_data = value, resp_err = 0.
      - Poll: pwr_status <= value; no resp_valid.
    - No match: increment the frame counter. On reaching TIMEOUT_FRAMES, return to IDLE.
      - Host read: resp_valid = 1, resp_err = 1, resp_data = 0xFFFF.
      - Poll: pwr_status unchanged.
- Host handshake:
  - Single-entry buffer. req_ready = 1 when init_done = 1, buffer empty, and no host command is outstanding.
  - Accept on any cycle where req_valid & req_ready; req_ready drops on the following cycle.
  - The buffer frees when the command is issued. A new request is not accepted until resp_valid of the previous one has pulsed.
- Poll counter:
  - Counts strobes only while init_done = 1.
  - On reaching POLL_FRAMES-1: wrap to 0 and set poll-pending. Further wraps while pending are absorbed.
  - poll-pending clears when the poll is issued.
- Simultaneous events: codec-ready loss in READ_WAIT completes the pending read as a timeout error immediately, then goes to WAIT_READY.
- resp_valid is high for exactly one cycle.

Optional Feature:
- Macro: AC97_STATUS_POLL_EN.
- Defined: periodic 0x26 polling as above; pwr_status is live.
- Undefined: poll counter, pending flag and poll path are removed. pwr_status is tied to 0x0000, and only host reads enter READ_WAIT.

Decomposition:
- Package ac97_pkg holds:
  - State enum (WAIT_READY, INIT, IDLE, READ_WAIT).
  - Register index constants (0x00, 0x02, 0x04, 0x18, 0x26).
  - Init ROM length (4) and entries.
  - Slot-field pack helpers: slot1 = {rnw, addr, 12'b0}; slot2 = {data, 4'b0}.
- One sub-module: ac97_init_rom, a combinational index -> {addr, data} lookup with a last flag.

Test Plan:
- Hold in_codec_ready = 0 for 5 frames, then 1 -> no valid slots during the 5 frames. The next 4 frames carry writes 0x00/0x0000, 0x02/0x0000, 0x18/0x0808, 0x04/0x0000. init_done rises on the 4th strobe edge.
- After init, host write addr 0x02 data 0x8000 -> next frame slot1 = 0x02000, slot2 = 0x80000, both valids = 1. resp_valid pulses with resp_err = 0.
- Host read 0x7C; codec returns in_slot1[18:12] = 0x7C, in_slot2 = 0x41440 two frames later -> resp_data = 0x4144, resp_err = 0, only one read issued.
- Host read 0x7E with no matching response -> after 4 frames, resp_valid with resp_err = 1, resp_data = 0xFFFF; req_ready is low throughout.
- With AC97_STATUS_POLL_EN defined: host request present in the same frame the poll becomes pending -> host command issued first, poll of 0x26 in the following frame. Response 0x000F sets pwr_status = 0x000F.
- Assert ac97_rst_b low in mid READ_WAIT -> all outputs 0 asynchronously. After release, the scheduler waits in WAIT_READY and re-runs init from entry 0.
